// File: rtl/spi_tft_screen_monitor_if.sv
// Bundles the SPI TFT link pins seen by the monitor and the decoded byte/pixel results.
// Latency: none; this is wiring only.
// Backpressure: none; the link is observed passively and every result is a one-cycle pulse.
interface spi_tft_screen_monitor_if;
  // link pins, observed in parallel with the panel
  logic        lcd_spi_sclk;
  logic        lcd_spi_mosi;
  logic        lcd_spi_cs;
  logic        lcd_dc;
  logic        lcd_reset;
  // decoded results
  logic        byte_valid_o;
  logic [7:0]  byte_o;
  logic        byte_is_data_o;
  logic        cmd_valid_o;
  logic [7:0]  cmd_o;
  logic        pix_valid_o;
  logic [15:0] pix_data_o;
  logic [15:0] pix_x_o;
  logic [15:0] pix_y_o;
  logic        frame_done_o;
  logic [1:0]  err_o;

  // the monitor: listens to the pins, produces results
  modport master (
    input  lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc, lcd_reset,
    output byte_valid_o, byte_o, byte_is_data_o, cmd_valid_o, cmd_o,
    output pix_valid_o, pix_data_o, pix_x_o, pix_y_o, frame_done_o, err_o
  );

  // the link driver / result consumer
  modport slave (
    output lcd_spi_sclk, lcd_spi_mosi, lcd_spi_cs, lcd_dc, lcd_reset,
    input  byte_valid_o, byte_o, byte_is_data_o, cmd_valid_o, cmd_o,
    input  pix_valid_o, pix_data_o, pix_x_o, pix_y_o, frame_done_o, err_o
  );
endinterface

// File: rtl/spi_tft_screen_monitor.sv
// Passive SPI TFT link decoder: bytes, CASET/RASET window, RAMWR RGB565 pixels with x/y.
// Latency: byte/cmd pulse 3 cycles after the sampling edge of the 8th sclk rise; pixel 1 cycle later.
// Backpressure: none; results are single-cycle pulses. Optional error pulses under SCREEN_MONITOR_ERR_EN.
module spi_tft_screen_monitor #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  spi_tft_screen_monitor_if.master mon
);

  localparam logic [15:0] XE_RST = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] YE_RST = 16'(SCREEN_HEIGHT - 1);
  localparam logic [7:0]  CMD_CASET = 8'h2A;
  localparam logic [7:0]  CMD_RASET = 8'h2B;
  localparam logic [7:0]  CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_RASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_SKIP  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers (never soft-reset, so lcd_reset itself keeps being seen)
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] dc_sync_q;
  logic [1:0] lrst_sync_q;

  // 2-flop synchronisers plus a third sclk flop for rising-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      dc_sync_q   <= 2'b00;
      lrst_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], mon.lcd_spi_sclk};
      mosi_sync_q <= {mosi_sync_q[0], mon.lcd_spi_mosi};
      cs_sync_q   <= {cs_sync_q[0], mon.lcd_spi_cs};
      dc_sync_q   <= {dc_sync_q[0], mon.lcd_dc};
      lrst_sync_q <= {lrst_sync_q[0], mon.lcd_reset};
    end
  end

  logic sclk_rise;
  logic mosi_s;
  logic cs_hi;
  logic dc_s;
  logic soft_rst;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_hi     = cs_sync_q[1];
  assign dc_s      = dc_sync_q[1];
  assign soft_rst  = ~lrst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Bit deserialiser
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] rx_byte_q;
  logic       rx_dc_q;
  logic       rx_done_q;
  logic       bit_take;

  // The 8th edge wins over a simultaneous cs rise, so a byte completing
  // exactly as cs goes high is still delivered.
  assign bit_take = sclk_rise & (~cs_hi | (bit_cnt_q == 3'd7));

  // shift mosi in MSB first; cs high drops any partial byte
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      rx_byte_q <= 8'd0;
      rx_dc_q   <= 1'b0;
      rx_done_q <= 1'b0;
    end else if (soft_rst) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      rx_byte_q <= 8'd0;
      rx_dc_q   <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      if (bit_take) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_done_q <= 1'b1;
          rx_byte_q <= {shift_q, mosi_s};
          rx_dc_q   <= dc_s;
        end
      end else if (cs_hi) begin
        bit_cnt_q <= 3'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte / command output stage
  // ---------------------------------------------------------------------------
  logic       byte_valid_q;
  logic [7:0] byte_q;
  logic       byte_is_data_q;
  logic       cmd_valid_q;
  logic [7:0] cmd_q;

  // publish each received byte; commands also update cmd_o
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_valid_q   <= 1'b0;
      byte_q         <= 8'd0;
      byte_is_data_q <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= 8'd0;
    end else if (soft_rst) begin
      byte_valid_q   <= 1'b0;
      byte_q         <= 8'd0;
      byte_is_data_q <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_q          <= 8'd0;
    end else begin
      byte_valid_q <= rx_done_q;
      cmd_valid_q  <= rx_done_q & ~rx_dc_q;
      if (rx_done_q) begin
        byte_q         <= rx_byte_q;
        byte_is_data_q <= rx_dc_q;
      end
      if (rx_done_q && !rx_dc_q) begin
        cmd_q <= rx_byte_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM, address window and pixel assembly
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [1:0]  arg_cnt_q, arg_cnt_d;
  logic [7:0]  arg0_q, arg0_d;
  logic [7:0]  arg1_q, arg1_d;
  logic [7:0]  arg2_q, arg2_d;
  logic [15:0] xs_q, xs_d, xe_q, xe_d;
  logic [15:0] ys_q, ys_d, ye_q, ye_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        phase_q, phase_d;
  logic [7:0]  hold_q, hold_d;
  logic        pix_vld_q, pix_vld_d;
  logic [15:0] pix_dat_q, pix_dat_d;
  logic [15:0] pix_x_q, pix_x_d;
  logic [15:0] pix_y_q, pix_y_d;
  logic        frame_q, frame_d;

  // state and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      arg_cnt_q <= 2'd0;
      arg0_q    <= 8'd0;
      arg1_q    <= 8'd0;
      arg2_q    <= 8'd0;
      xs_q      <= 16'd0;
      xe_q      <= XE_RST;
      ys_q      <= 16'd0;
      ye_q      <= YE_RST;
      x_q       <= 16'd0;
      y_q       <= 16'd0;
      phase_q   <= 1'b0;
      hold_q    <= 8'd0;
      pix_vld_q <= 1'b0;
      pix_dat_q <= 16'd0;
      pix_x_q   <= 16'd0;
      pix_y_q   <= 16'd0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arg_cnt_q <= arg_cnt_d;
      arg0_q    <= arg0_d;
      arg1_q    <= arg1_d;
      arg2_q    <= arg2_d;
      xs_q      <= xs_d;
      xe_q      <= xe_d;
      ys_q      <= ys_d;
      ye_q      <= ye_d;
      x_q       <= x_d;
      y_q       <= y_d;
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      pix_vld_q <= pix_vld_d;
      pix_dat_q <= pix_dat_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      frame_q   <= frame_d;
    end
  end

  // next state: commands pick the mode, data bytes feed arguments or pixels
  always_comb begin
    state_d   = state_q;
    arg_cnt_d = arg_cnt_q;
    arg0_d    = arg0_q;
    arg1_d    = arg1_q;
    arg2_d    = arg2_q;
    xs_d      = xs_q;
    xe_d      = xe_q;
    ys_d      = ys_q;
    ye_d      = ye_q;
    x_d       = x_q;
    y_d       = y_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    pix_vld_d = 1'b0;
    pix_dat_d = pix_dat_q;
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    frame_d   = 1'b0;

    if (byte_valid_q) begin
      if (!byte_is_data_q) begin
        // any command abandons partially received arguments
        arg_cnt_d = 2'd0;
        case (byte_q)
          CMD_CASET: state_d = ST_CASET;
          CMD_RASET: state_d = ST_RASET;
          CMD_RAMWR: begin
            state_d = ST_RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
            phase_d = 1'b0;
          end
          default:   state_d = ST_SKIP;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_RASET: begin
            arg_cnt_d = arg_cnt_q + 2'd1;
            case (arg_cnt_q)
              2'd0:    arg0_d = byte_q;
              2'd1:    arg1_d = byte_q;
              2'd2:    arg2_d = byte_q;
              default: begin
                // window registers only move once all four arguments are in
                state_d = ST_IDLE;
                if (state_q == ST_CASET) begin
                  xs_d = {arg0_q, arg1_q};
                  xe_d = {arg2_q, byte_q};
                end else begin
                  ys_d = {arg0_q, arg1_q};
                  ye_d = {arg2_q, byte_q};
                end
              end
            endcase
          end
          ST_RAMWR: begin
            if (!phase_q) begin
              hold_d  = byte_q;
              phase_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              pix_vld_d = 1'b1;
              pix_dat_d = {hold_q, byte_q};
              pix_x_d   = x_q;
              pix_y_d   = y_q;
              // equality-only wrap: a start beyond the end just runs through 0xFFFF
              if (x_q == xe_q) begin
                x_d = xs_q;
                if (y_q == ye_q) begin
                  y_d     = ys_q;
                  frame_d = 1'b1;
                end else begin
                  y_d = y_q + 16'd1;
                end
              end else begin
                x_d = x_q + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    // panel reset returns the decoder to its power-on state
    if (soft_rst) begin
      state_d   = ST_IDLE;
      arg_cnt_d = 2'd0;
      arg0_d    = 8'd0;
      arg1_d    = 8'd0;
      arg2_d    = 8'd0;
      xs_d      = 16'd0;
      xe_d      = XE_RST;
      ys_d      = 16'd0;
      ye_d      = YE_RST;
      x_d       = 16'd0;
      y_d       = 16'd0;
      phase_d   = 1'b0;
      hold_d    = 8'd0;
      pix_vld_d = 1'b0;
      pix_dat_d = 16'd0;
      pix_x_d   = 16'd0;
      pix_y_d   = 16'd0;
      frame_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Error pulses
  // ---------------------------------------------------------------------------
`ifdef SCREEN_MONITOR_ERR_EN
  logic [1:0] err_q;
  logic       cs_abort;
  logic       arg_trunc;

  assign cs_abort  = cs_hi & ~bit_take & (bit_cnt_q != 3'd0);
  assign arg_trunc = byte_valid_q & ~byte_is_data_q &
                     ((state_q == ST_CASET) | (state_q == ST_RASET)) &
                     (arg_cnt_q != 2'd0);

  // err[0]: partial byte dropped by cs; err[1]: command cut an argument list short
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_q <= 2'b00;
    end else if (soft_rst) begin
      err_q <= 2'b00;
    end else begin
      err_q <= {arg_trunc, cs_abort};
    end
  end

  assign mon.err_o = err_q;
`else
  assign mon.err_o = 2'b00;
`endif

  assign mon.byte_valid_o   = byte_valid_q;
  assign mon.byte_o         = byte_q;
  assign mon.byte_is_data_o = byte_is_data_q;
  assign mon.cmd_valid_o    = cmd_valid_q;
  assign mon.cmd_o          = cmd_q;
  assign mon.pix_valid_o    = pix_vld_q;
  assign mon.pix_data_o     = pix_dat_q;
  assign mon.pix_x_o        = pix_x_q;
  assign mon.pix_y_o        = pix_y_q;
  assign mon.frame_done_o   = frame_q;

endmodule

// File: doc/spi_tft_screen_monitor.md
# spi_tft_screen_monitor

Receive-side decoder for the 4-wire SPI TFT link (sclk/mosi/cs/dc) that the screen driver transmits. The block passively samples the link in the `sys_clk` domain and deserialises bytes. It tracks the column/row address window commands and the memory-write command (0x2A/0x2B/0x2C), and reconstructs RGB565 pixels with their x/y coordinates. It sits on the LCD pins, in parallel with the panel, and is used for on-chip loopback checking and frame capture.

## Interface
Parameters:
- `SCREEN_WIDTH`, 320: default column window end + 1 after reset.
- `SCREEN_HEIGHT`, 240: default row window end + 1 after reset.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `lcd_spi_sclk`  in  1  link SPI clock, asynchronous to `sys_clk`.
- `lcd_spi_mosi`  in  1  link serial data.
- `lcd_spi_cs`  in  1  link chip select, active low.
- `lcd_dc`  in  1  0 = command byte, 1 = data byte.
- `lcd_reset`  in  1  panel reset, active low; acts as a soft reset for this block.
- `byte_valid_o`  out  1  one-cycle pulse: a byte has been received.
- `byte_o`  out  8  received byte.
- `byte_is_data_o`  out  1  `lcd_dc` value latched with the byte.
- `cmd_valid_o`  out  1  one-cycle pulse on every command byte.
- `cmd_o`  out  8  last command byte.
- `pix_valid_o`  out  1  one-cycle pulse: a pixel has been assembled.
- `pix_data_o`  out  16  RGB565 pixel; first byte received is [15:8].
- `pix_x_o`, `pix_y_o`  out  16 each  coordinate of `pix_data_o`.
- `frame_done_o`  out  1  pulse together with the pixel at (xe, ye).
- `err_o`  out  2  [0] partial byte aborted by cs; [1] command truncated its arguments.

## Operation
- `lcd_spi_sclk`, `lcd_spi_mosi`, `lcd_spi_cs`, `lcd_dc` and `lcd_reset` each pass through a 2-flop synchroniser. A third flop on sclk provides rising-edge detection.
- SPI mode 0, MSB first. Each sclk rising edge with cs low shifts in mosi. `lcd_dc` is latched at the 8th edge. A 3-bit counter wraps at 8 and emits a byte.
- Synchronised cs high clears the bit counter. A nonzero count at that moment is discarded and sets err[0]. Command/RAMWR state persists across cs toggles.
- Window registers xs/xe/ys/ye (16 b each) reset to 0 / `SCREEN_WIDTH`-1 / 0 / `SCREEN_HEIGHT`-1.
- FSM states: IDLE, CASET, RASET, RAMWR, SKIP.
  - Any command byte pulses `cmd_valid_o` and selects the next state: 0x2A→CASET, 0x2B→RASET, 0x2C→RAMWR, anything else→SKIP. IDLE exits only on a command.
  - CASET/RASET take 4 data bytes into a 2-bit argument counter: start hi, start lo, end hi, end lo. The registers update only when the 4th byte arrives, then the state goes to IDLE.
  - A command byte arriving with the argument count in 1..3 sets err[1]; the partial arguments are dropped.
  - Entering RAMWR loads x=xs, y=ys and clears the byte-phase flag.
  - In RAMWR, even data bytes are held and odd data bytes complete a pixel. x increments; at x==xe, x→xs and y increments; at (xe, ye), x→xs, y→ys and `frame_done_o` pulses.
  - SKIP ignores data bytes.
- Start > end is accepted unchanged. Wrap compares use equality only, so the counter runs to 0xFFFF and wraps naturally.
- Synchronised `lcd_reset` low: same effect as `sys_rst_n` except the synchronisers keep running.

## Timing
- Reset values: all outputs 0; FSM in IDLE; window at its defaults.
- Input constraint: sclk high and low phases each ≥ 3 `sys_clk` periods. mosi/dc stable ±1 `sys_clk` around the sclk rise.
- `byte_valid_o` and `cmd_valid_o` assert exactly 3 cycles after the first `sys_clk` edge that samples the 8th sclk high on the pin.
- `byte_o`, `byte_is_data_o` and `cmd_o` change on the cycle the pulse goes high and hold until the next byte.
- `pix_valid_o` asserts 1 cycle after the odd byte's `byte_valid_o`. `pix_x_o`/`pix_y_o` hold the coordinates of that pixel; the counter advance is visible at the next pixel only.
- The `err_o` bits are one-cycle pulses.
- Simultaneous cs rise and 8th edge: the byte completes first, with no error.

## Configuration
- `SCREEN_MONITOR_ERR_EN` defined: the err[0] and err[1] detection logic is present.
- Not defined: `err_o` is tied to 2'b00, and decoding behaves identically otherwise.

## Test plan
- Reset, then RAMWR followed by 4 data bytes 0xF8,0x00,0x07,0xE0 → pixels 0xF800 at (0,0) and 0x07E0 at (1,0).
- CASET 0,10,0,11 + RASET 0,5,0,6 + RAMWR + 8 bytes → pixels at (10,5),(11,5),(10,6),(11,6); `frame_done_o` with the 4th pixel; 5th pixel back at (10,5).
- Full default frame of 76800 pixels → `frame_done_o` with pixel (319,239) only, and the next pixel at (0,0).
- cs raised after 5 bits, then byte 0x2C → err_o=2'b01, then `cmd_valid_o` with `cmd_o`=0x2C, and no stray byte.
- CASET with 2 arguments, then RAMWR → err_o=2'b10, the window stays at 0..319, and the first pixel is at (0,0).
- `lcd_reset` pulsed low mid-RAMWR → FSM in IDLE, window at its defaults, and data bytes produce no `pix_valid_o` until the next 0x2C.
